// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the adder_arbiter block: FSM state encoding,
// default sizes and the round-robin pointer advance.
package adder_arb_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   localparam int DEFAULT_WIDTH   = 8;
   localparam int DEFAULT_NUM_REQ = 4;

   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
      return (ptr + 1 >= n) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/adder_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after ptr_i,
// searching upward modulo NUM_REQ. Purely combinational.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    ptr_i,
   input  logic               en_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [ID_W-1:0]    gnt_idx_o,
   output logic               gnt_valid_o
);

   always_comb begin
      int unsigned idx;
      idx         = 0;
      gnt_o       = '0;
      gnt_idx_o   = '0;
      gnt_valid_o = 1'b0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         idx = (32'(ptr_i) + off) % NUM_REQ;
         if (en_i && !gnt_valid_o && req_i[ID_W'(idx)]) begin
            gnt_valid_o = 1'b1;
            gnt_idx_o   = ID_W'(idx);
         end
      end
      if (gnt_valid_o) gnt_o[gnt_idx_o] = 1'b1;
   end

endmodule

// File: rtl/adder_arbiter.sv
// Shared registered adder with round-robin request arbitration and a single
// result port. Define ADDER_ARB_SAT_EN to saturate the sum on carry-out.
module adder_arbiter
   import adder_arb_pkg::*;
#(
   parameter  int WIDTH   = DEFAULT_WIDTH,
   parameter  int NUM_REQ = DEFAULT_NUM_REQ,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NUM_REQ-1:0]       req_valid_i,
   output logic [NUM_REQ-1:0]       req_ready_o,
   input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
   input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
   output logic                     rsp_valid_o,
   input  logic                     rsp_ready_i,
   output logic [ID_W-1:0]          rsp_id_o,
   output logic [WIDTH-1:0]         rsp_sum_o,
   output logic                     rsp_carry_o
);

   // Handshake: a request transfers on a cycle where req_valid_i[r] & req_ready_o[r];
   // a result transfers where rsp_valid_o & rsp_ready_i. A result slot freed by
   // rsp_ready_i can be refilled on the same edge.

   state_e            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [WIDTH-1:0]  sum_q, sum_d;
   logic              carry_q, carry_d;

   logic              can_accept;
   logic              arb_en;
   logic              accept;
   logic [ID_W-1:0]   gnt_idx;
   logic [WIDTH-1:0]  op_a, op_b;
   logic [WIDTH:0]    raw_sum;
   logic [WIDTH-1:0]  new_sum;

   assign can_accept = (state_q == EMPTY) | rsp_ready_i;
   assign arb_en     = can_accept & ~rst_i;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr (
      .req_i       (req_valid_i),
      .ptr_i       (ptr_q),
      .en_i        (arb_en),
      .gnt_o       (req_ready_o),
      .gnt_idx_o   (gnt_idx),
      .gnt_valid_o (accept)
   );

   assign op_a    = req_a_i[32'(gnt_idx)*WIDTH +: WIDTH];
   assign op_b    = req_b_i[32'(gnt_idx)*WIDTH +: WIDTH];
   assign raw_sum = {1'b0, op_a} + {1'b0, op_b};

`ifdef ADDER_ARB_SAT_EN
   assign new_sum = raw_sum[WIDTH] ? '1 : raw_sum[WIDTH-1:0];
`else
   assign new_sum = raw_sum[WIDTH-1:0];
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      if (accept) begin
         state_d = FULL;
         ptr_d   = ID_W'(rr_next(32'(gnt_idx), NUM_REQ));
         id_d    = gnt_idx;
         sum_d   = new_sum;
         carry_d = raw_sum[WIDTH];
      end else if (state_q == FULL && rsp_ready_i) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= EMPTY;
         ptr_q   <= '0;
         id_q    <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
      end
   end

   assign rsp_valid_o = (state_q == FULL);
   assign rsp_id_o    = id_q;
   assign rsp_sum_o   = sum_q;
   assign rsp_carry_o = carry_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter (WIDTH=8, NUM_REQ=4); expected values are
// hand-computed. Define ADDER_ARB_SAT_EN for both bench and RTL to test saturation.
module tb_adder_arbiter;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [3:0]  req_valid_i;
   logic [3:0]  req_ready_o;
   logic [31:0] req_a_i;
   logic [31:0] req_b_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [1:0]  rsp_id_o;
   logic [7:0]  rsp_sum_o;
   logic        rsp_carry_o;

   int total = 0;
   int bad   = 0;

   adder_arbiter #(.WIDTH(8), .NUM_REQ(4)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_a_i     (req_a_i),
      .req_b_i     (req_b_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_id_o    (rsp_id_o),
      .rsp_sum_o   (rsp_sum_o),
      .rsp_carry_o (rsp_carry_o)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled on the falling edge.
   task automatic set_op(input int r, input logic [7:0] a, input logic [7:0] b);
      req_valid_i[r]    = 1'b1;
      req_a_i[r*8 +: 8] = a;
      req_b_i[r*8 +: 8] = b;
   endtask

   task automatic test_reset();
      rst_i       = 1'b1;
      req_valid_i = 4'hF;
      rsp_ready_i = 1'b0;
      req_a_i     = 32'h44332211;
      req_b_i     = 32'h01010101;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if ({rsp_valid_o, req_ready_o, rsp_id_o, rsp_sum_o, rsp_carry_o} !== 16'h0) begin
            bad++;
            $display("FAIL reset_outputs cyc=%0d got valid=%0b ready=%b id=%0d sum=%h carry=%0b exp all zero",
                     i, rsp_valid_o, req_ready_o, rsp_id_o, rsp_sum_o, rsp_carry_o);
         end
      end
      rst_i       = 1'b0;
      req_valid_i = 4'h0;
   endtask

   task automatic test_single();
      set_op(2, 8'h12, 8'h34);
      #1;
      total++;
      if (req_ready_o !== 4'b0100) begin
         bad++; $display("FAIL single_grant got=%b exp=0100", req_ready_o);
      end
      @(negedge clk);
      req_valid_i = 4'h0;
      total++;
      if ({rsp_valid_o, rsp_id_o, rsp_sum_o, rsp_carry_o} !== {1'b1, 2'd2, 8'h46, 1'b0}) begin
         bad++;
         $display("FAIL single_rsp got valid=%0b id=%0d sum=%h carry=%0b exp 1/2/46/0",
                  rsp_valid_o, rsp_id_o, rsp_sum_o, rsp_carry_o);
      end
      rsp_ready_i = 1'b1;
      @(negedge clk);
      total++;
      if (rsp_valid_o !== 1'b0 || rsp_sum_o !== 8'h46) begin
         bad++; $display("FAIL single_drain got valid=%0b sum=%h exp 0/46", rsp_valid_o, rsp_sum_o);
      end
   endtask

   // Pointer is 3 on entry, so the rotation starts at requester 3.
   task automatic test_rr();
      logic [1:0] exp_g[8];
      exp_g = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
      for (int r = 0; r < 4; r++) set_op(r, 8'(8'h10 * (r + 1)), 8'(r + 1));
      rsp_ready_i = 1'b1;
      for (int i = 0; i <= 8; i++) begin
         #1;
         if (i < 8) begin
            total++;
            if (req_ready_o !== 4'(1 << exp_g[i])) begin
               bad++; $display("FAIL rr_grant i=%0d got=%b exp_idx=%0d", i, req_ready_o, exp_g[i]);
            end
         end
         if (i > 0) begin
            total++;
            if ({rsp_valid_o, rsp_id_o, rsp_sum_o, rsp_carry_o} !==
                {1'b1, exp_g[i-1], 8'(8'h11 * (exp_g[i-1] + 1)), 1'b0}) begin
               bad++;
               $display("FAIL rr_rsp i=%0d got valid=%0b id=%0d sum=%h exp id=%0d sum=%h",
                        i, rsp_valid_o, rsp_id_o, rsp_sum_o, exp_g[i-1], 8'(8'h11 * (exp_g[i-1] + 1)));
            end
         end
         @(negedge clk);
         if (i == 7) req_valid_i = 4'h0;
      end
      total++;
      if (rsp_valid_o !== 1'b0) begin
         bad++; $display("FAIL rr_drain got valid=%0b exp 0", rsp_valid_o);
      end
   endtask

   // Pointer is 3 on entry; requester 1 is the only one valid.
   task automatic test_back_pressure();
      rsp_ready_i = 1'b0;
      set_op(1, 8'h20, 8'h05);
      @(negedge clk);
      req_valid_i = 4'h0;
      set_op(0, 8'h40, 8'h02);
      for (int i = 0; i < 5; i++) begin
         #1;
         total++;
         if ({rsp_valid_o, rsp_id_o, rsp_sum_o, rsp_carry_o, req_ready_o} !==
             {1'b1, 2'd1, 8'h25, 1'b0, 4'b0000}) begin
            bad++;
            $display("FAIL bp_hold cyc=%0d got valid=%0b id=%0d sum=%h carry=%0b ready=%b exp 1/1/25/0/0000",
                     i, rsp_valid_o, rsp_id_o, rsp_sum_o, rsp_carry_o, req_ready_o);
         end
         @(negedge clk);
      end
      rsp_ready_i = 1'b1;
      #1;
      total++;
      if (req_ready_o !== 4'b0001) begin
         bad++; $display("FAIL bp_release_grant got=%b exp=0001", req_ready_o);
      end
      @(negedge clk);
      req_valid_i = 4'h0;
      total++;
      if ({rsp_valid_o, rsp_id_o, rsp_sum_o} !== {1'b1, 2'd0, 8'h42}) begin
         bad++;
         $display("FAIL bp_next_rsp got valid=%0b id=%0d sum=%h exp 1/0/42", rsp_valid_o, rsp_id_o, rsp_sum_o);
      end
      @(negedge clk);
      total++;
      if (rsp_valid_o !== 1'b0) begin
         bad++; $display("FAIL bp_drain got valid=%0b exp 0", rsp_valid_o);
      end
   endtask

   // Pointer is 1 on entry.
   task automatic test_overflow();
      logic [7:0] exp_s1, exp_s2;
`ifdef ADDER_ARB_SAT_EN
      exp_s1 = 8'hFF;
      exp_s2 = 8'hFF;
`else
      exp_s1 = 8'h00;
      exp_s2 = 8'hFE;
`endif
      rsp_ready_i = 1'b1;
      set_op(1, 8'hFF, 8'h01);
      @(negedge clk);
      req_valid_i = 4'h0;
      set_op(2, 8'hFF, 8'hFF);
      total++;
      if ({rsp_valid_o, rsp_id_o, rsp_sum_o, rsp_carry_o} !== {1'b1, 2'd1, exp_s1, 1'b1}) begin
         bad++;
         $display("FAIL ovf_ff_01 got valid=%0b id=%0d sum=%h carry=%0b exp 1/1/%h/1",
                  rsp_valid_o, rsp_id_o, rsp_sum_o, rsp_carry_o, exp_s1);
      end
      @(negedge clk);
      req_valid_i = 4'h0;
      total++;
      if ({rsp_valid_o, rsp_id_o, rsp_sum_o, rsp_carry_o} !== {1'b1, 2'd2, exp_s2, 1'b1}) begin
         bad++;
         $display("FAIL ovf_ff_ff got valid=%0b id=%0d sum=%h carry=%0b exp 1/2/%h/1",
                  rsp_valid_o, rsp_id_o, rsp_sum_o, rsp_carry_o, exp_s2);
      end
      @(negedge clk);
   endtask

   // Pointer is 3 on entry; r1 is accepted (pointer -> 2), then reset must
   // bring the pointer back to 0 so r0 wins over r1 and r2.
   task automatic test_midop_reset();
      logic [1:0] exp_g[3];
      exp_g = '{2'd0, 2'd1, 2'd2};
      rsp_ready_i = 1'b0;
      set_op(1, 8'h55, 8'h11);
      @(negedge clk);
      req_valid_i = 4'h0;
      set_op(0, 8'h01, 8'h10);
      set_op(1, 8'h02, 8'h10);
      set_op(2, 8'h03, 8'h10);
      total++;
      if ({rsp_valid_o, rsp_id_o, rsp_sum_o} !== {1'b1, 2'd1, 8'h66}) begin
         bad++;
         $display("FAIL mid_pre_rsp got valid=%0b id=%0d sum=%h exp 1/1/66", rsp_valid_o, rsp_id_o, rsp_sum_o);
      end
      rst_i = 1'b1;
      @(negedge clk);
      total++;
      if (rsp_valid_o !== 1'b0 || req_ready_o !== 4'b0000) begin
         bad++; $display("FAIL mid_in_reset got valid=%0b ready=%b exp 0/0000", rsp_valid_o, req_ready_o);
      end
      rst_i       = 1'b0;
      rsp_ready_i = 1'b1;
      for (int i = 0; i <= 3; i++) begin
         #1;
         if (i < 3) begin
            total++;
            if (req_ready_o !== 4'(1 << exp_g[i])) begin
               bad++; $display("FAIL mid_grant i=%0d got=%b exp_idx=%0d", i, req_ready_o, exp_g[i]);
            end
         end
         total++;
         if (i == 0) begin
            if (rsp_valid_o !== 1'b0) begin
               bad++; $display("FAIL mid_no_rsp got valid=%0b exp 0", rsp_valid_o);
            end
         end else if ({rsp_valid_o, rsp_id_o, rsp_sum_o} !== {1'b1, exp_g[i-1], 8'(8'h10 + i)}) begin
            bad++;
            $display("FAIL mid_rsp i=%0d got valid=%0b id=%0d sum=%h exp id=%0d sum=%h",
                     i, rsp_valid_o, rsp_id_o, rsp_sum_o, exp_g[i-1], 8'(8'h10 + i));
         end
         @(negedge clk);
         req_valid_i[exp_g[i < 3 ? i : 2]] = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_rr();
      test_back_pressure();
      test_overflow();
      test_midop_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
